// File: rtl/tna_pkg.sv
// Shared definitions for the ternary neuron accumulate-and-threshold stage.
//
// Contents:
//   ACT_POS / ACT_NEG / ACT_ZERO : two-bit ternary activation codes
//   PC11_MAX                     : largest count an exact popcount11 can produce
//   tna_state_e                  : frame controller states
package tna_pkg;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_NEG  = 2'b11;
    localparam logic [1:0] ACT_ZERO = 2'b00;

    localparam int PC11_MAX = 11;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } tna_state_e;

endpackage

// File: rtl/tna_thresh_cmp.sv
// Ternary threshold comparator: maps a signed frame total onto a ternary
// activation. A total equal to either threshold maps to zero.
//
// Ports:
//   acc_next : in  signed [ACC_W-1:0]  frame total being classified
//   thr_hi   : in  signed [ACC_W-1:0]  upper threshold (total above -> +1)
//   thr_lo   : in  signed [ACC_W-1:0]  lower threshold (total below -> -1)
//   act      : out [1:0]               ACT_POS / ACT_NEG / ACT_ZERO
module tna_thresh_cmp
    import tna_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic signed [ACC_W-1:0] acc_next,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic        [1:0]       act
);

    always_comb begin
        act = ACT_ZERO;
        if (acc_next > thr_hi) begin
            act = ACT_POS;
        end else if (acc_next < thr_lo) begin
            act = ACT_NEG;
        end
    end

endmodule

// File: rtl/ternary_neuron_acc.sv
// Accumulate-and-threshold stage behind a pair of popcount11 units.
// Each accepted beat adds (pos_cnt - neg_cnt) to a signed frame total; the
// final beat of a frame (in_last, or the MAX_CHUNKS-th beat) classifies the
// total against thr_hi/thr_lo and presents one ternary activation on a
// valid/ready output until the consumer takes it.
//
// Optional build macro: TNA_CHK_EN enables the sticky err flag (out-of-range
// popcounts, or a frame closed without in_last). Without it err is 0.
//
// Ports:
//   clk        : in   clock, rising edge
//   rst_n      : in   synchronous active-low reset
//   in_valid   : in   beat valid
//   in_ready   : out  beat can be accepted (high in ACC)
//   in_last    : in   final beat of the frame
//   pos_cnt    : in   [CNT_W-1:0] popcount of +1-weighted inputs
//   neg_cnt    : in   [CNT_W-1:0] popcount of -1-weighted inputs
//   thr_hi     : in   signed [ACC_W-1:0] upper threshold
//   thr_lo     : in   signed [ACC_W-1:0] lower threshold
//   out_valid  : out  result valid (high in HOLD)
//   out_ready  : in   consumer accepts result
//   act        : out  [1:0] 01 = +1, 11 = -1, 00 = 0
//   sum        : out  signed [ACC_W-1:0] frame total of last result
//   err        : out  sticky error flag
//
// States:
//   state | meaning
//   ------+---------------------------------------------------------------
//   ACC   | accepting beats, accumulating the current frame
//   HOLD  | result presented on act/sum, waiting for out_ready
module ternary_neuron_acc
    import tna_pkg::*;
#(
    parameter  int CNT_W      = 4,
    parameter  int MAX_CHUNKS = 8,
    localparam int ACC_W      = $clog2(MAX_CHUNKS * (2**CNT_W - 1) + 1) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic        [CNT_W-1:0] pos_cnt,
    input  logic        [CNT_W-1:0] neg_cnt,
    input  logic signed [ACC_W-1:0] thr_hi,
    input  logic signed [ACC_W-1:0] thr_lo,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [1:0]       act,
    output logic signed [ACC_W-1:0] sum,
    output logic                    err
);

    localparam int               IDX_W    = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_CHUNKS - 1);

    tna_state_e state_q, state_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] pos_ext, neg_ext;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic        [IDX_W-1:0] idx_q, idx_d;
    logic        [1:0]       act_q, act_d, act_cmp;
    logic                    accept;
    logic                    at_limit;
    logic                    final_beat;

    // Both handshake outputs decode straight from the state register, so
    // neither has a combinational path from the opposite side's handshake.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);

    assign accept     = in_valid & in_ready;
    assign at_limit   = (idx_q == IDX_LAST);
    assign final_beat = accept & (in_last | at_limit);

    // Counts are unsigned: zero-extend before the signed add/subtract.
    assign pos_ext  = {{(ACC_W-CNT_W){1'b0}}, pos_cnt};
    assign neg_ext  = {{(ACC_W-CNT_W){1'b0}}, neg_cnt};
    assign acc_next = acc_q + pos_ext - neg_ext;

    tna_thresh_cmp #(
        .ACC_W (ACC_W)
    ) u_thresh_cmp (
        .acc_next (acc_next),
        .thr_hi   (thr_hi),
        .thr_lo   (thr_lo),
        .act      (act_cmp)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        act_d   = act_q;
        unique case (state_q)
            ACC: begin
                if (final_beat) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    sum_d   = acc_next;
                    act_d   = act_cmp;
                    state_d = HOLD;
                end else if (accept) begin
                    acc_d = acc_next;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            act_q   <= ACT_ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            act_q   <= act_d;
        end
    end

    assign act = act_q;
    assign sum = sum_q;

`ifdef TNA_CHK_EN
    logic err_q;
    logic range_bad;
    logic forced_last;

    // Approximate popcounts may exceed the exact 0..11 range; still summed.
    assign range_bad   = (pos_cnt > CNT_W'(PC11_MAX)) | (neg_cnt > CNT_W'(PC11_MAX));
    assign forced_last = at_limit & ~in_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept & (range_bad | forced_last)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_neuron_acc.sv
module tb_ternary_neuron_acc;

    localparam int CNT_W      = 4;
    localparam int MAX_CHUNKS = 8;
    localparam int ACC_W      = 8;
`ifdef TNA_CHK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] pos_cnt   = '0;
    logic [CNT_W-1:0] neg_cnt   = '0;
    logic [ACC_W-1:0] thr_hi    = '0;
    logic [ACC_W-1:0] thr_lo    = '0;
    logic             in_ready;
    logic             out_valid;
    logic [1:0]       act;
    logic [ACC_W-1:0] sum;
    logic             err;

    ternary_neuron_acc #(
        .CNT_W      (CNT_W),
        .MAX_CHUNKS (MAX_CHUNKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .pos_cnt   (pos_cnt),
        .neg_cnt   (neg_cnt),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act       (act),
        .sum       (sum),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic cmp(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: a frame is a list of beat contributions; the result
    // is their plain integer sum classified against the thresholds.
    int frame[$];
    bit m_hold = 1'b0;
    int m_sum  = 0;
    int m_act  = 0;
    bit m_err  = 1'b0;
    int m_total, m_hi, m_lo;

    always @(posedge clk) begin
        if (!rst_n) begin
            frame.delete();
            m_hold = 1'b0;
            m_sum  = 0;
            m_act  = 0;
            m_err  = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) begin
                frame.push_back(int'(pos_cnt) - int'(neg_cnt));
                if (CHK != 0 && (pos_cnt > 11 || neg_cnt > 11)) m_err = 1'b1;
                if (in_last || frame.size() == MAX_CHUNKS) begin
                    if (CHK != 0 && !in_last) m_err = 1'b1;
                    m_total = 0;
                    foreach (frame[i]) m_total += frame[i];
                    m_hi  = int'($signed(thr_hi));
                    m_lo  = int'($signed(thr_lo));
                    m_sum = m_total;
                    if (m_total > m_hi)      m_act = 1;
                    else if (m_total < m_lo) m_act = 3;
                    else                     m_act = 0;
                    frame.delete();
                    m_hold = 1'b1;
                end
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("in_ready",  int'(in_ready),      int'(!m_hold));
            cmp("out_valid", int'(out_valid),     int'(m_hold));
            cmp("act",       int'(act),           m_act);
            cmp("sum",       int'($signed(sum)),  m_sum);
            cmp("err",       int'(err),           int'(m_err));
        end
    end

    task automatic set_thr(input int hi, input int lo);
        thr_hi = hi[ACC_W-1:0];
        thr_lo = lo[ACC_W-1:0];
    endtask

    // All directed tasks start and end at posedge + 1.
    task automatic beat(input int p, input int n, input bit last);
        in_valid = 1'b1;
        pos_cnt  = p[CNT_W-1:0];
        neg_cnt  = n[CNT_W-1:0];
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        cmp(name, int'(out_valid), 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        set_thr(3, -3);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        rst_n  = 1'b1;
        cmp("rst_out_valid", int'(out_valid), 0);
        cmp("rst_in_ready",  int'(in_ready),  1);
        cmp("rst_sum",       int'($signed(sum)), 0);
        cmp("rst_act",       int'(act), 0);
        cmp("rst_err",       int'(err), 0);

        // single-beat frame
        beat(7, 2, 1'b1);
        wait_out("t1_valid");
        cmp("t1_sum", int'($signed(sum)), 5);
        cmp("t1_act", int'(act), 1);
        consume();
        cmp("t1_in_ready_after", int'(in_ready), 1);

        // three-beat frame
        beat(3, 5, 1'b0);
        beat(1, 6, 1'b0);
        beat(2, 4, 1'b1);
        wait_out("t2_valid");
        cmp("t2_sum", int'($signed(sum)), -9);
        cmp("t2_act", int'(act), 3);
        cmp("t2_in_ready", int'(in_ready), 0);
        consume();

        // equality with thr_hi gives zero, one below gives +1
        set_thr(4, -3);
        beat(4, 0, 1'b1);
        wait_out("t3a_valid");
        cmp("t3a_act", int'(act), 0);
        consume();
        set_thr(3, -3);
        beat(4, 0, 1'b1);
        wait_out("t3b_valid");
        cmp("t3b_act", int'(act), 1);
        consume();

        // backpressure
        beat(2, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cmp("t4_hold_valid", int'(out_valid), 1);
            cmp("t4_hold_sum", int'($signed(sum)), 1);
            cmp("t4_hold_act", int'(act), 0);
            cmp("t4_hold_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        consume();
        cmp("t4_in_ready_after", int'(in_ready), 1);
        beat(0, 4, 1'b1);
        wait_out("t4b_valid");
        cmp("t4b_sum", int'($signed(sum)), -4);
        cmp("t4b_act", int'(act), 3);
        consume();

        // forced last
        for (int i = 0; i < 8; i++) begin
            beat(15, 0, 1'b0);
            if (i == 6) cmp("t5_not_yet", int'(out_valid), 0);
        end
        cmp("t5_valid", int'(out_valid), 1);
        cmp("t5_sum", int'($signed(sum)), 120);
        cmp("t5_act", int'(act), 1);
        cmp("t5_err", int'(err), CHK);
        consume();

        // reset mid-frame
        beat(5, 0, 1'b0);
        beat(6, 0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmp("t6_rst_sum", int'($signed(sum)), 0);
        cmp("t6_rst_err", int'(err), 0);
        cmp("t6_rst_valid", int'(out_valid), 0);
        set_thr(0, -3);
        beat(1, 0, 1'b1);
        wait_out("t6_valid");
        cmp("t6_sum", int'($signed(sum)), 1);
        cmp("t6_act", int'(act), 1);
        consume();

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int a, b;
            rst_n    = ($urandom_range(0, 499) != 0);
            in_valid = ($urandom_range(0, 9) < 7);
            pos_cnt  = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(12, 15))
                                                    : CNT_W'($urandom_range(0, 11));
            neg_cnt  = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(12, 15))
                                                    : CNT_W'($urandom_range(0, 11));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = $urandom_range(0, 1) != 0;
            a = int'($urandom_range(0, 80)) - 40;
            b = int'($urandom_range(0, 80)) - 40;
            if (a > b) set_thr(a, b);
            else       set_thr(b, a);
            @(posedge clk); #1;
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
